// File: rtl/rs_issue_scheduler.sv
// Issue scheduler for a 16-entry reservation station: tag wakeup, oldest-ready
// select per functional unit, valid/ready issue slots and free-mask publication.
module rs_issue_scheduler #(
    parameter  int unsigned RS_DEPTH = 16,
    parameter  int unsigned TAG_W    = 6,
    parameter  int unsigned NUM_FU   = 3,
    localparam int unsigned IDX_W    = $clog2(RS_DEPTH),
    localparam int unsigned CNT_W    = $clog2(RS_DEPTH + 1),
    localparam int unsigned FU_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      alloc0_valid,
    input  logic [IDX_W-1:0]          alloc0_idx,
    input  logic [FU_W-1:0]           alloc0_fu,
    input  logic [TAG_W-1:0]          alloc0_tag1,
    input  logic [TAG_W-1:0]          alloc0_tag2,
    input  logic                      alloc0_rdy1,
    input  logic                      alloc0_rdy2,
    input  logic                      alloc1_valid,
    input  logic [IDX_W-1:0]          alloc1_idx,
    input  logic [FU_W-1:0]           alloc1_fu,
    input  logic [TAG_W-1:0]          alloc1_tag1,
    input  logic [TAG_W-1:0]          alloc1_tag2,
    input  logic                      alloc1_rdy1,
    input  logic                      alloc1_rdy2,
    input  logic [NUM_FU-1:0]         wake_valid,
    input  logic [NUM_FU*TAG_W-1:0]   wake_tag,
    output logic [NUM_FU-1:0]         issue_valid,
    output logic [NUM_FU*IDX_W-1:0]   issue_idx,
    input  logic [NUM_FU-1:0]         issue_ready,
    output logic [RS_DEPTH-1:0]       rs_free,
    output logic [CNT_W-1:0]          rs_count,
    output logic                      alloc_err
);

    // older[i][j] = 1 means entry j is older than entry i
    logic [RS_DEPTH-1:0] valid, picked, rdy1, rdy2;
    logic [FU_W-1:0]     fu     [RS_DEPTH];
    logic [TAG_W-1:0]    tag1   [RS_DEPTH];
    logic [TAG_W-1:0]    tag2   [RS_DEPTH];
    logic [RS_DEPTH-1:0] older  [RS_DEPTH];

    logic [RS_DEPTH-1:0]     valid_n, picked_n, rdy1_n, rdy2_n, freed;
    logic [FU_W-1:0]         fu_n    [RS_DEPTH];
    logic [TAG_W-1:0]        tag1_n  [RS_DEPTH];
    logic [TAG_W-1:0]        tag2_n  [RS_DEPTH];
    logic [RS_DEPTH-1:0]     older_n [RS_DEPTH];
    logic [NUM_FU-1:0]       issue_valid_n, accept, load;
    logic [NUM_FU*IDX_W-1:0] issue_idx_n;
    logic [CNT_W-1:0]        rs_count_n;
    logic                    alloc_err_n, alloc0_ok, alloc1_ok;

    logic [RS_DEPTH-1:0] elig      [NUM_FU];
    logic [IDX_W-1:0]    sel_idx   [NUM_FU];
    logic [NUM_FU-1:0]   sel_found;

    function automatic logic woken(input logic [TAG_W-1:0]        tag,
                                   input logic [NUM_FU-1:0]       wv,
                                   input logic [NUM_FU*TAG_W-1:0] wt);
        woken = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (wv[k] && (wt[k*TAG_W +: TAG_W] == tag)) woken = 1'b1;
        end
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                elig[k][i] = valid[i] & ~picked[i] & rdy1[i] & rdy2[i] & (fu[i] == FU_W'(k));
            end
        end
    end

    // Oldest eligible entry per FU: no other eligible entry is older than it
    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            sel_found[k] = 1'b0;
            sel_idx[k]   = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (elig[k][i] && ((elig[k] & older[i]) == '0)) begin
                    sel_found[k] = 1'b1;
                    sel_idx[k]   = IDX_W'(i);
                end
            end
        end
    end

    assign accept    = issue_valid & issue_ready;
    assign load      = ~issue_valid | accept;
    assign alloc0_ok = alloc0_valid && !valid[alloc0_idx] && (alloc0_fu < FU_W'(NUM_FU));
    assign alloc1_ok = alloc1_valid && !valid[alloc1_idx] && (alloc1_fu < FU_W'(NUM_FU))
                       && !(alloc0_valid && (alloc0_idx == alloc1_idx));

    always_comb begin
        valid_n       = valid;
        picked_n      = picked;
        rdy1_n        = rdy1;
        rdy2_n        = rdy2;
        fu_n          = fu;
        tag1_n        = tag1;
        tag2_n        = tag2;
        older_n       = older;
        issue_valid_n = issue_valid;
        issue_idx_n   = issue_idx;
        freed         = '0;
        rs_count_n    = '0;
        alloc_err_n   = (alloc0_valid && !alloc0_ok) || (alloc1_valid && !alloc1_ok);

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid[i] && woken(tag1[i], wake_valid, wake_tag)) rdy1_n[i] = 1'b1;
            if (valid[i] && woken(tag2[i], wake_valid, wake_tag)) rdy2_n[i] = 1'b1;
        end

        for (int k = 0; k < NUM_FU; k++) begin
            if (accept[k]) begin
                freed[issue_idx[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (freed[i]) begin
                valid_n[i]  = 1'b0;
                picked_n[i] = 1'b0;
                older_n[i]  = '0;
            end
            older_n[i] = older_n[i] & ~freed;
        end

        // Slot reload; picked entries are excluded from eligibility, so no double issue
        for (int k = 0; k < NUM_FU; k++) begin
            if (load[k]) begin
                issue_valid_n[k] = sel_found[k];
                if (sel_found[k]) begin
                    issue_idx_n[k*IDX_W +: IDX_W] = sel_idx[k];
                    picked_n[sel_idx[k]]          = 1'b1;
                end
            end
        end

        if (alloc0_ok) begin
            valid_n[alloc0_idx]  = 1'b1;
            picked_n[alloc0_idx] = 1'b0;
            fu_n[alloc0_idx]     = alloc0_fu;
            tag1_n[alloc0_idx]   = alloc0_tag1;
            tag2_n[alloc0_idx]   = alloc0_tag2;
            rdy1_n[alloc0_idx]   = alloc0_rdy1 | woken(alloc0_tag1, wake_valid, wake_tag);
            rdy2_n[alloc0_idx]   = alloc0_rdy2 | woken(alloc0_tag2, wake_valid, wake_tag);
            for (int i = 0; i < RS_DEPTH; i++) older_n[i][alloc0_idx] = 1'b0;
            older_n[alloc0_idx]  = valid & ~freed;
        end
        if (alloc1_ok) begin
            valid_n[alloc1_idx]  = 1'b1;
            picked_n[alloc1_idx] = 1'b0;
            fu_n[alloc1_idx]     = alloc1_fu;
            tag1_n[alloc1_idx]   = alloc1_tag1;
            tag2_n[alloc1_idx]   = alloc1_tag2;
            rdy1_n[alloc1_idx]   = alloc1_rdy1 | woken(alloc1_tag1, wake_valid, wake_tag);
            rdy2_n[alloc1_idx]   = alloc1_rdy2 | woken(alloc1_tag2, wake_valid, wake_tag);
            for (int i = 0; i < RS_DEPTH; i++) older_n[i][alloc1_idx] = 1'b0;
            older_n[alloc1_idx]  = valid & ~freed;
            if (alloc0_ok) older_n[alloc1_idx][alloc0_idx] = 1'b1;
        end

        if (flush) begin
            valid_n       = '0;
            picked_n      = '0;
            older_n       = '{default: '0};
            issue_valid_n = '0;
            issue_idx_n   = '0;
            alloc_err_n   = 1'b0;
        end

        for (int i = 0; i < RS_DEPTH; i++) rs_count_n = rs_count_n + CNT_W'(valid_n[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= '0;
            picked      <= '0;
            rdy1        <= '0;
            rdy2        <= '0;
            fu          <= '{default: '0};
            tag1        <= '{default: '0};
            tag2        <= '{default: '0};
            older       <= '{default: '0};
            issue_valid <= '0;
            issue_idx   <= '0;
            rs_free     <= '1;
            rs_count    <= '0;
            alloc_err   <= 1'b0;
        end else begin
            valid       <= valid_n;
            picked      <= picked_n;
            rdy1        <= rdy1_n;
            rdy2        <= rdy2_n;
            fu          <= fu_n;
            tag1        <= tag1_n;
            tag2        <= tag2_n;
            older       <= older_n;
            issue_valid <= issue_valid_n;
            issue_idx   <= issue_idx_n;
            rs_free     <= ~valid_n;
            rs_count    <= rs_count_n;
            alloc_err   <= alloc_err_n;
        end
    end

endmodule
